// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after a fixed 33-cycle latency, or after 1 cycle for a zero divisor.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] work;
    logic [31:0] divisor;
    logic        signed_op;
    logic        sign1;
    logic        sign2;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    // The stored partial remainder is always below the divisor, so the 65th
    // bit only exists transiently in the shifted value.
    assign shifted = {work, 1'b0};
    assign diff    = shifted[64:32] - {1'b0, divisor};

    assign quot_fix = (signed_op && (sign1 ^ sign2)) ? -work[31:0]  : work[31:0];
    assign rem_fix  = (signed_op && sign1)           ? -work[63:32] : work[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FREE;
            cnt       <= 6'd0;
            work      <= 64'd0;
            divisor   <= 32'd0;
            signed_op <= 1'b0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state     <= ST_ON;
                            cnt       <= 6'd0;
                            work      <= {32'd0, abs1};
                            divisor   <= abs2;
                            signed_op <= signed_div_i;
                            sign1     <= opdata1_i[31];
                            sign2     <= opdata2_i[31];
                        end
                    end
                end
                ST_BYZERO: begin
                    state    <= ST_END;
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                end
                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else if (cnt == 6'd32) begin
                        state    <= ST_END;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        work <= diff[32] ? shifted[63:0]
                                         : {diff[31:0], shifted[31:1], 1'b1};
                        cnt  <= cnt + 6'd1;
                    end
                end
                ST_END: begin
                    if (!start_i || annul_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state    <= ST_FREE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares them whenever ready_o rises.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result_o;
    logic        ready_o;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q[$];
    bit          ready_prev = 1'b0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (opdata1),
        .opdata2_i   (opdata2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1 && !ready_prev) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_ready: got result %h, expected no ready", result_o);
                end else begin
                    check_output("result", result_o, exp_q.pop_front());
                end
            end
            ready_prev = (ready_o === 1'b1);
        end
    end

    task automatic apply_stimulus(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] expected, input int latency,
                                  input int hold, input bit scramble);
        int k;
        @(negedge clk);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(expected);
        @(negedge clk);
        k = 0;
        while (ready_o !== 1'b1 && k < 60) begin
            if (scramble) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            @(negedge clk);
            k++;
        end
        check_output("latency", 64'(k), 64'(latency));
        if (k >= 60) exp_q.delete();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("hold_ready", {63'd0, ready_o}, 64'd1);
            check_output("hold_result", result_o, expected);
        end
        start = 1'b0;
        @(negedge clk);
        check_output("drop_ready", {63'd0, ready_o}, 64'd0);
        check_output("drop_result", result_o, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen_ready;
        rst        = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_ready", {63'd0, ready_o}, 64'd0);
        check_output("reset_result", result_o, 64'd0);
        rst = 1'b0;

        apply_stimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b0);
        apply_stimulus(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 2, 1'b0);
        apply_stimulus(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1, 1'b0);
        apply_stimulus(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0, 1'b0);
        apply_stimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0, 1'b0);
        apply_stimulus(1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 33, 0, 1'b0);
        apply_stimulus(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 0, 1'b0);
        apply_stimulus(1'b1, 32'd1234, 32'd0, 64'd0, 1, 10, 1'b0);

        // Abort at E10: no result may ever appear for this operation.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        seen_ready = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ready_o === 1'b1) seen_ready = 1'b1;
            @(negedge clk);
        end
        check_output("annul_no_ready", {63'd0, seen_ready}, 64'd0);

        // Reset at E20 of an in-flight divide.
        signed_div = 1'b0;
        opdata1    = 32'd200;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(negedge clk);
        repeat (19) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_output("rst_on_ready", {63'd0, ready_o}, 64'd0);
        check_output("rst_on_result", result_o, 64'd0);
        rst = 1'b0;

        apply_stimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b0);
        apply_stimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b1);

        // Reset while a finished result is being held.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd50;
        opdata2    = 32'd5;
        start      = 1'b1;
        exp_q.push_back(64'h00000000_0000000A);
        for (int i = 0; i < 60 && ready_o !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_output("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check_output("rst_end_result", result_o, 64'd0);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check_output("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. While a divide is in flight the execute stage holds `start_i` high and raises its pipeline stall request. The divider produces `{remainder, quotient}` for the execute stage to write into HI/LO: HI receives the remainder, LO the quotient. It uses a restoring algorithm, one quotient bit per cycle, with a fixed latency independent of operand values.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = DIV (two's-complement), 0 = DIVU
- opdata1_i  in  32  dividend (rs)
- opdata2_i  in  32  divisor (rt)
- start_i  in  1  request; held high by execute stage until result consumed
- annul_i  in  1  abort current divide (pipeline flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}; registered
- ready_o  out  1  result_o valid; registered

## Operation
- States: FREE, BYZERO, ON, END. Reset state FREE; reset values result_o=0, ready_o=0. rst has priority over every other input, in every state.
- FREE
  - start_i=1, annul_i=0, opdata2_i=0 → BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 → ON.
    - Capture operands; for signed_div_i=1, capture absolute values of negative operands.
    - Also capture signed_div_i, the original sign bits, and zero the 6-bit iteration counter.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO → END unconditionally, with result_o=0 and ready_o=1. No exception is raised; the MIPS result is UNPREDICTABLE and this design defines it as 0.
- ON, counter<32, annul_i=0: one restoring step per cycle.
  - Shift the 65-bit working register {partial remainder, dividend/quotient} left by one.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0.
  - Counter +1.
- ON, counter==32 → END. Apply sign correction, then register result_o and set ready_o=1.
  - For signed: quotient is negated if the dividend and divisor signs differ.
  - For signed: remainder is negated if the dividend is negative.
  - Unsigned results are unmodified.
- ON, annul_i=1 → FREE. ready_o=0, result_o=0; the partial result is discarded.
- END
  - start_i=1: hold result_o and ready_o.
  - start_i=0: → FREE, ready_o=0, result_o=0.
  - annul_i in END behaves like start_i=0.
- Operand inputs are ignored after capture; changing opdata*_i during ON does not affect the result.
- Arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. The absolute value of 0x80000000 is treated as unsigned 2^31.

## Timing
- E0 = the clock edge at which start_i is sampled high in FREE.
- Nonzero divisor: iterations occur at E1..E32, the END transition at E33, and ready_o is high from E33 to the edge at which start_i is sampled low. Total latency is 33 cycles.
- Zero divisor: BYZERO at E0, END at E1; ready_o high from E1.
- ready_o is high for a minimum of one cycle. The execute stage drops its stall on the cycle ready_o=1 and deasserts start_i; at the next edge the block returns to FREE.
- A new start_i may be accepted at the edge immediately after return to FREE, so back-to-back divides are separated by at least one FREE cycle.
- annul_i is sampled every edge in ON. Abort takes effect at that edge; ready_o never rises for the aborted operation.
- rst asserted in any state: at the next edge state=FREE, counter=0, result_o=0, ready_o=0.

## Test plan
- Unsigned: DIVU 100/7, start held → ready_o rises at E33, result_o=64'h00000002_0000000E; drop start_i → ready_o=0, result_o=0 next edge.
- Signed: DIV 0xFFFFFFF9 (−7) / 2 → result_o=64'hFFFFFFFF_FFFFFFFD. DIV 7 / 0xFFFFFFFE → result_o=64'h00000001_FFFFFFFD.
- Extremes:
  - DIVU 0xFFFFFFFF/1 → 64'h00000000_FFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → 64'h00000000_80000000.
  - DIVU 5/9 → 64'h00000005_00000000.
- Divide by zero: DIV 1234/0 → ready_o high from E1, result_o=0. Holding start_i for 10 cycles keeps ready_o=1; dropping it returns the block to FREE.
- Abort/reset:
  - annul_i pulse at E10 → ready_o stays 0 through E40.
  - rst at E20 of a second divide → outputs 0 at E21.
  - A following DIVU 100/7 still completes correctly at its own E33.
- Operand change: alter opdata1_i/opdata2_i every cycle during ON of DIVU 100/7 → result still 64'h00000002_0000000E.
